// File: rtl/ps2_kbd_rx.sv
// PS/2 keyboard receiver: synchronise, deframe, decode E0/F0 prefixes, count distinct presses, buffer events in a FWFT FIFO.
// Optional build macro PS2_PARITY_CHK_EN enables odd-parity checking of each received frame.
module ps2_kbd_rx #(
    parameter int DEPTH   = 8,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 50000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ps2_clk,
    input  logic             ps2_data,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_break,
    output logic             evt_ext,
    output logic [CNT_W-1:0] press_cnt,
    output logic             overflow,
    output logic             frame_err,
    input  logic             clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT + 1);
`ifdef PS2_PARITY_CHK_EN
    localparam bit PAR_CHK = 1'b1;
`else
    localparam bit PAR_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {S_IDLE, S_EXT, S_BRK, S_EXT_BRK} state_t;

    logic [2:0]    r_ps2c_sync;
    logic [1:0]    r_ps2d_sync;
    logic [3:0]    r_bit_cnt;
    logic [9:0]    r_shift;
    logic [TW-1:0] r_to_cnt;
    logic          r_byte_vld;
    logic [7:0]    r_byte;
    state_t        r_state;
    state_t        w_state_nxt;
    logic          w_emit, w_ext, w_brk;
    logic          r_held_vld;
    logic [8:0]    r_held;
    logic [9:0]    r_mem [DEPTH];
    logic [AW:0]   r_wr_ptr, r_rd_ptr;

    logic w_fall, w_data, w_last_bit, w_frame_ok, w_frame_bad, w_to_hit;
    logic w_empty, w_full, w_push, w_pop, w_wr_en, w_key_match;
    logic [9:0] w_head;

    assign w_fall      = (r_ps2c_sync[2:1] == 2'b10);
    assign w_data      = r_ps2d_sync[1];
    assign w_last_bit  = w_fall && (r_bit_cnt == 4'd10);
    // r_shift holds start..parity; the stop bit is the one arriving now.
    assign w_frame_ok  = !r_shift[0] && w_data && (!PAR_CHK || (^r_shift[9:1]));
    assign w_frame_bad = w_last_bit && !w_frame_ok;
    assign w_to_hit    = (r_bit_cnt != 4'd0) && !w_fall && (r_to_cnt == TW'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_ps2c_sync <= 3'b111;
            r_ps2d_sync <= 2'b11;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            r_ps2c_sync <= {r_ps2c_sync[1:0], ps2_clk};
            r_ps2d_sync <= {r_ps2d_sync[0], ps2_data};
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_to_cnt   <= '0;
            r_byte_vld <= 1'b0;
            r_byte     <= '0;
        end else begin
            r_byte_vld <= 1'b0;
            if (w_fall) begin
                r_to_cnt <= '0;
                if (r_bit_cnt == 4'd10) begin
                    r_bit_cnt  <= '0;
                    r_byte_vld <= w_frame_ok;
                    r_byte     <= r_shift[8:1];
                end else begin
                    r_shift   <= {w_data, r_shift[9:1]};
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                end
            end else if (w_to_hit) begin
                r_bit_cnt <= '0;
                r_to_cnt  <= '0;
            end else if (r_bit_cnt != 4'd0) begin
                r_to_cnt <= r_to_cnt + TW'(1);
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
        w_state_nxt = r_state;
        w_emit      = 1'b0;
        w_ext       = (r_state == S_EXT) || (r_state == S_EXT_BRK);
        w_brk       = (r_state == S_BRK) || (r_state == S_EXT_BRK);
        if (r_byte_vld) begin
            case (r_byte)
                8'hE0:   w_state_nxt = S_EXT;
                8'hF0:   w_state_nxt = w_ext ? S_EXT_BRK : S_BRK;
                default: begin
                    w_emit      = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            endcase
        end
    end

    assign w_key_match = r_held_vld && (r_held == {w_ext, r_byte});

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            press_cnt  <= '0;
            r_held_vld <= 1'b0;
            r_held     <= '0;
        end else if (w_emit) begin
            if (!w_brk) begin
                if (!w_key_match) press_cnt <= press_cnt + CNT_W'(1);
                r_held     <= {w_ext, r_byte};
                r_held_vld <= 1'b1;
            end else if (w_key_match) begin
                r_held_vld <= 1'b0;
            end
        end
    end

    assign w_empty   = (r_wr_ptr == r_rd_ptr);
    assign w_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push    = w_emit;
    assign w_pop     = evt_valid && evt_ready;
    assign w_wr_en   = w_push && (!w_full || w_pop);
    assign w_head    = r_mem[r_rd_ptr[AW-1:0]];
    assign evt_valid = !w_empty;
    assign evt_code  = w_empty ? 8'h00 : w_head[7:0];
    assign evt_break = !w_empty && w_head[8];
    assign evt_ext   = !w_empty && w_head[9];

    // NOTE: storage array has no reset; outputs are gated by empty so stale contents never leak.
    always_ff @(posedge clk) begin
        if (w_wr_en) r_mem[r_wr_ptr[AW-1:0]] <= {w_ext, w_brk, r_byte};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)   r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Sticky flags: a set in the same cycle as clr_err takes priority.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (w_push && w_full && !w_pop) overflow <= 1'b1;
            else if (clr_err)               overflow <= 1'b0;
            if (w_frame_bad || w_to_hit)    frame_err <= 1'b1;
            else if (clr_err)               frame_err <= 1'b0;
        end
    end

endmodule
